// File: rtl/lc3_exec_unit_pkg.sv
// Shared definitions for the LC3 execute/writeback slice:
// opcodes, sequencer states, NZP bit positions and the default width.
package lc3_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  // Bit positions inside the {N,Z,P} condition-code vector
  localparam int unsigned NZP_N = 2;
  localparam int unsigned NZP_Z = 1;
  localparam int unsigned NZP_P = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_e;

endpackage

// File: rtl/lc3_exec_unit_if.sv
// Decoder-to-execute handshake: one decoded operate instruction per
// in_valid/in_ready transfer. master = decoder, slave = execute unit.
interface lc3_exec_unit_if #(
  parameter int unsigned RA_W = 3
) ();

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [RA_W-1:0] in_dr;
  logic [RA_W-1:0] in_sr1;
  logic [RA_W-1:0] in_sr2;
  logic            in_imm_sel;
  logic [4:0]      in_imm5;

  modport master (
    output in_valid, in_op, in_dr, in_sr1, in_sr2, in_imm_sel, in_imm5,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_dr, in_sr1, in_sr2, in_imm_sel, in_imm5,
    output in_ready
  );

endinterface

// File: rtl/lc3_exec_unit_alu.sv
// Combinational LC3 operate ALU: ADD / AND / NOT on two WIDTH-bit operands.
// legal_o flags whether op_i is one of the supported operate opcodes.
module lc3_alu
  import lc3_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             legal_o
);

  // Opcode decode and result select; carry out of ADD is discarded
  always_comb begin
    result_o = '0;
    legal_o  = 1'b1;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_NOT:  result_o = ~a_i;
      default: legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/lc3_exec_unit.sv
// LC3 execute/writeback sequencer for ADD/AND/NOT.
// IDLE -> ISSUE -> EXEC -> WB: presents register-file read addresses,
// waits out the file's one-cycle registered read, computes the result and
// drives the file's write port and the NZP condition codes.
// Optional build macro LC3_EXEC_IMM_BYPASS_EN: lets an instruction that needs
// no SR2 skip ISSUE when its SR1 address is already presented and unwritten.
// The writeback bus is named global_bus ('global' is an SV keyword).
module lc3_exec_unit
  import lc3_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RA_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  lc3_exec_unit_if.slave   dec,
  output logic [RA_W-1:0]  SR1,
  output logic [RA_W-1:0]  SR2,
  input  logic [WIDTH-1:0] SR1_OUT,
  input  logic [WIDTH-1:0] SR2_OUT,
  output logic [RA_W-1:0]  DR,
  output logic             ld_reg,
  output logic [WIDTH-1:0] global_bus,
  output logic             done,
  output logic             err,
  output logic [2:0]       nzp
);

  state_e           state_q, state_d;
  logic [RA_W-1:0]  sr1_q, sr1_d, sr2_q, sr2_d, dr_q, dr_d;
  logic [3:0]       op_q, op_d;
  logic             imm_sel_q, imm_sel_d;
  logic [4:0]       imm5_q, imm5_d;
  logic [WIDTH-1:0] global_q, global_d;
  logic             ld_reg_q, ld_reg_d, done_q, done_d, err_q, err_d;
  logic [2:0]       nzp_q, nzp_d, nzp_res;
  logic [WIDTH-1:0] operand_b, alu_res;
  logic             alu_legal;
  logic             accept;
  logic             skip_issue;

  assign accept = (state_q == IDLE) && dec.in_valid;

  assign operand_b = imm_sel_q ? {{(WIDTH-5){imm5_q[4]}}, imm5_q} : SR2_OUT;

  lc3_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i     (op_q),
    .a_i      (SR1_OUT),
    .b_i      (operand_b),
    .result_o (alu_res),
    .legal_o  (alu_legal)
  );

  // One-hot condition code of the ALU result
  always_comb begin
    nzp_res = '0;
    if (alu_res[WIDTH-1])   nzp_res[NZP_N] = 1'b1;
    else if (alu_res == '0) nzp_res[NZP_Z] = 1'b1;
    else                    nzp_res[NZP_P] = 1'b1;
  end

`ifdef LC3_EXEC_IMM_BYPASS_EN
  logic sr1_ok_q, sr1_ok_d;

  // SR1_OUT is already valid when the same address has been held and not written
  assign skip_issue = sr1_ok_q && (dec.in_sr1 == sr1_q) &&
                      (dec.in_imm_sel || (dec.in_op == OP_NOT));

  // Track whether the presented SR1 address still reads current data
  always_comb begin
    sr1_ok_d = sr1_ok_q;
    if (accept) sr1_ok_d = 1'b1;
    if ((state_q == EXEC) && alu_legal && (dr_q == sr1_q)) sr1_ok_d = 1'b0;
  end

  // SR1-valid tracking register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr1_ok_q <= 1'b0;
    else        sr1_ok_q <= sr1_ok_d;
  end
`else
  assign skip_issue = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dec.in_valid) state_d = skip_issue ? EXEC : ISSUE;
      ISSUE:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; WB strobes are set up in EXEC so they are registered
  always_comb begin
    dec.in_ready = (state_q == IDLE);
    sr1_d        = sr1_q;
    sr2_d        = sr2_q;
    dr_d         = dr_q;
    op_d         = op_q;
    imm_sel_d    = imm_sel_q;
    imm5_d       = imm5_q;
    global_d     = global_q;
    nzp_d        = nzp_q;
    ld_reg_d     = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    if (accept) begin
      sr1_d     = dec.in_sr1;
      sr2_d     = dec.in_sr2;
      dr_d      = dec.in_dr;
      op_d      = dec.in_op;
      imm_sel_d = dec.in_imm_sel;
      imm5_d    = dec.in_imm5;
    end
    if (state_q == EXEC) begin
      global_d = alu_res;
      done_d   = 1'b1;
      ld_reg_d = alu_legal;
      err_d    = !alu_legal;
      if (alu_legal) nzp_d = nzp_res;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr1_q     <= '0;
      sr2_q     <= '0;
      dr_q      <= '0;
      op_q      <= '0;
      imm_sel_q <= 1'b0;
      imm5_q    <= '0;
      global_q  <= '0;
      ld_reg_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      nzp_q     <= 3'b010;
    end else begin
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      dr_q      <= dr_d;
      op_q      <= op_d;
      imm_sel_q <= imm_sel_d;
      imm5_q    <= imm5_d;
      global_q  <= global_d;
      ld_reg_q  <= ld_reg_d;
      done_q    <= done_d;
      err_q     <= err_d;
      nzp_q     <= nzp_d;
    end
  end

  assign SR1        = sr1_q;
  assign SR2        = sr2_q;
  assign DR         = dr_q;
  assign ld_reg     = ld_reg_q;
  assign global_bus = global_q;
  assign done       = done_q;
  assign err        = err_q;
  assign nzp        = nzp_q;

endmodule

// File: tb/tb_lc3_exec_unit.sv
// Self-checking bench for lc3_exec_unit: directed vector table, hand-written
// back-to-back / reset sequences, and a randomized run against an
// architectural reference model (register array + condition codes).
module tb_lc3_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sr1_a, sr2_a, dr_a;
  logic [15:0] sr1_out = '0, sr2_out = '0;
  logic        ld_reg, done, err;
  logic [15:0] glob;
  logic [2:0]  nzp;

  int total = 0;
  int bad   = 0;

  logic [15:0] rf [8];
  logic        tb_we = 1'b0;
  logic [2:0]  tb_wa = '0;
  logic [15:0] tb_wd = '0;

  lc3_exec_unit_if #(.RA_W(3)) dec_if ();

  lc3_exec_unit #(.WIDTH(16), .RA_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec        (dec_if),
    .SR1        (sr1_a),
    .SR2        (sr2_a),
    .SR1_OUT    (sr1_out),
    .SR2_OUT    (sr2_out),
    .DR         (dr_a),
    .ld_reg     (ld_reg),
    .global_bus (glob),
    .done       (done),
    .err        (err),
    .nzp        (nzp)
  );

  always #5 clk = ~clk;

  // Register file environment: registered read, write on ld_reg, bench preload port
  always @(posedge clk) begin
    sr1_out <= rf[sr1_a];
    sr2_out <= rf[sr2_a];
    if (ld_reg)     rf[dr_a]  <= glob;
    else if (tb_we) rf[tb_wa] <= tb_wd;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Reference: architectural result and legality from the instruction rules
  function automatic logic [15:0] ref_res(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] r2, input logic isel,
                                          input logic [4:0] imm);
    int iv;
    int sum;
    logic [15:0] b;
    iv  = imm[4] ? int'(imm) - 32 : int'(imm);
    b   = isel ? iv[15:0] : r2;
    sum = (int'(a) + int'(b)) % 65536;
    if (op == 4'b0001)      return sum[15:0];
    else if (op == 4'b0101) return a & b;
    else if (op == 4'b1001) return ~a;
    return 16'h0000;
  endfunction

  function automatic logic ref_legal(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1001);
  endfunction

  function automatic logic [2:0] ref_nzp(input logic [15:0] v);
    if (v == 16'h0000) return 3'b010;
    if (v >= 16'h8000) return 3'b100;
    return 3'b001;
  endfunction

  // Issue one instruction and observe 10 cycles; lat = sample index of done
  task automatic run(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                     input logic [2:0] s2, input logic isel, input logic [4:0] imm,
                     output logic [15:0] g, output logic [2:0] n, output logic e,
                     output logic [2:0] dro, output int lat, output int ldcnt);
    int w;
    w = 0; g = '0; n = '0; e = 1'b0; dro = '0; lat = -1; ldcnt = 0;
    while (!dec_if.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!dec_if.in_ready) chk("ready_timeout", 32'd0, 32'd1);
    dec_if.in_op = op; dec_if.in_dr = d; dec_if.in_sr1 = s1; dec_if.in_sr2 = s2;
    dec_if.in_imm_sel = isel; dec_if.in_imm5 = imm; dec_if.in_valid = 1'b1;
    @(posedge clk); #1;
    dec_if.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ld_reg) ldcnt++;
      if (done && lat < 0) begin
        lat = k; g = glob; n = nzp; e = err; dro = dr_a;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  d;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic        isel;
    logic [4:0]  imm;
    logic [15:0] g;
    logic [2:0]  n;
    logic        e;
  } vec_t;

  vec_t tbl [7];
  logic [15:0] ref_rf [8];

  initial begin
    logic [15:0] g, exp_g;
    logic [2:0]  n, dro, exp_n;
    logic        e, lg;
    int          lat, ldcnt, low;
    logic [3:0]  op;
    logic [2:0]  d, s1, s2;
    logic        isel;
    logic [4:0]  imm;

    tbl[0] = '{4'b0001, 3'd3, 3'd1, 3'd2, 1'b0, 5'b00000, 16'h0008, 3'b001, 1'b0};
    tbl[1] = '{4'b0001, 3'd0, 3'd7, 3'd0, 1'b1, 5'b10000, 16'hFFF1, 3'b100, 1'b0};
    tbl[2] = '{4'b0001, 3'd0, 3'd6, 3'd0, 1'b1, 5'b00001, 16'h8000, 3'b100, 1'b0};
    tbl[3] = '{4'b0101, 3'd3, 3'd4, 3'd5, 1'b0, 5'b00000, 16'h0000, 3'b010, 1'b0};
    tbl[4] = '{4'b1001, 3'd2, 3'd4, 3'd0, 1'b0, 5'b00000, 16'h0F0F, 3'b001, 1'b0};
    tbl[5] = '{4'b0000, 3'd1, 3'd1, 3'd2, 1'b0, 5'b00000, 16'h0000, 3'b001, 1'b1};
    tbl[6] = '{4'b0101, 3'd6, 3'd5, 3'd0, 1'b1, 5'b11111, 16'h0F0F, 3'b001, 1'b0};

    dec_if.in_valid = 1'b0; dec_if.in_op = '0; dec_if.in_dr = '0; dec_if.in_sr1 = '0;
    dec_if.in_sr2 = '0; dec_if.in_imm_sel = 1'b0; dec_if.in_imm5 = '0;
    for (int i = 0; i < 8; i++) rf[i] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", dec_if.in_ready, 1'b1);
    chk("rst_nzp", nzp, 3'b010);
    chk("rst_strobes", {ld_reg, done, err}, 3'b000);
    chk("rst_global", glob, 16'h0000);
    chk("rst_addr", {sr1_a, sr2_a, dr_a}, 9'd0);
    rst_n = 1'b1;

    preload(3'd1, 16'h0005); preload(3'd2, 16'h0003); preload(3'd4, 16'hF0F0);
    preload(3'd5, 16'h0F0F); preload(3'd6, 16'h7FFF); preload(3'd7, 16'h0001);
    preload(3'd0, 16'h0000); preload(3'd3, 16'h0000);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run(tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].isel, tbl[i].imm,
          g, n, e, dro, lat, ldcnt);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_err", i), e, tbl[i].e);
      chk($sformatf("v%0d_nzp", i), n, tbl[i].n);
      chk($sformatf("v%0d_ldcnt", i), ldcnt, tbl[i].e ? 0 : 1);
      if (!tbl[i].e) begin
        chk($sformatf("v%0d_global", i), g, tbl[i].g);
        chk($sformatf("v%0d_dr", i), dro, tbl[i].d);
        chk($sformatf("v%0d_rfwrite", i), rf[tbl[i].d], tbl[i].g);
      end
    end
    chk("illegal_kept_r1", rf[1], 16'h0005);

    // Back-to-back with in_valid held; second reads first's DR
    while (!dec_if.in_ready) begin @(posedge clk); #1; end
    dec_if.in_op = 4'b0001; dec_if.in_dr = 3'd1; dec_if.in_sr1 = 3'd1;
    dec_if.in_imm_sel = 1'b1; dec_if.in_imm5 = 5'b00001; dec_if.in_valid = 1'b1;
    @(posedge clk); #1;
    dec_if.in_dr = 3'd2; dec_if.in_sr1 = 3'd1; dec_if.in_sr2 = 3'd1; dec_if.in_imm_sel = 1'b0;
    low = 0;
    for (int k = 0; k < 8; k++) begin
      if (dec_if.in_ready) break;
      low++;
      @(posedge clk); #1;
    end
    chk("b2b_ready_low", low, 3);
    @(posedge clk); #1;
    dec_if.in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      if (done && lat < 0) begin lat = k; g = glob; end
      @(posedge clk); #1;
    end
    chk("b2b_latency", lat, 2);
    chk("b2b_first_write", rf[1], 16'h0006);
    chk("b2b_raw_global", g, 16'h000C);

    // Reset pulse in EXEC: no write, immediate reset values
    while (!dec_if.in_ready) begin @(posedge clk); #1; end
    dec_if.in_op = 4'b0001; dec_if.in_dr = 3'd3; dec_if.in_sr1 = 3'd1;
    dec_if.in_sr2 = 3'd1; dec_if.in_imm_sel = 1'b0; dec_if.in_valid = 1'b1;
    @(posedge clk); #1;
    dec_if.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstx_strobes", {ld_reg, done, err}, 3'b000);
    chk("rstx_ready", dec_if.in_ready, 1'b1);
    chk("rstx_nzp", nzp, 3'b010);
    chk("rstx_global", glob, 16'h0000);
    chk("rstx_addr", {sr1_a, sr2_a, dr_a}, 9'd0);
    @(posedge clk); #1;
    chk("rstx_held_ld", ld_reg, 1'b0);
    rst_n = 1'b1;
    ldcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ld_reg) ldcnt++;
      if (k == 0) begin
        chk("rstx_ready_after", dec_if.in_ready, 1'b1);
        chk("rstx_nzp_after", nzp, 3'b010);
      end
    end
    chk("rstx_no_write", ldcnt, 0);
    chk("rstx_r3_kept", rf[3], 16'h0000);

    // Randomized instructions against the architectural reference
    for (int i = 0; i < 8; i++) begin
      ref_rf[i] = 16'($urandom);
      preload(3'(i), ref_rf[i]);
    end
    exp_n = 3'b010;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 4'b0001;
        3, 4, 5: op = 4'b0101;
        6, 7, 8: op = 4'b1001;
        default: op = 4'b1111;
      endcase
      d = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom);
      isel = 1'($urandom); imm = 5'($urandom);
      lg = ref_legal(op);
      exp_g = ref_res(op, ref_rf[s1], ref_rf[s2], isel, imm);
      if (lg) begin
        ref_rf[d] = exp_g;
        exp_n = ref_nzp(exp_g);
      end
      run(op, d, s1, s2, isel, imm, g, n, e, dro, lat, ldcnt);
      chk($sformatf("r%0d_latency", i), lat, 2);
      chk($sformatf("r%0d_err", i), e, !lg);
      chk($sformatf("r%0d_nzp", i), n, exp_n);
      chk($sformatf("r%0d_ldcnt", i), ldcnt, lg ? 1 : 0);
      if (lg) begin
        chk($sformatf("r%0d_global", i), g, exp_g);
        chk($sformatf("r%0d_dr", i), dro, d);
      end
    end
    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), rf[i], ref_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
